theta_stage: RTL and testbench

Theta-step engine for the encoder datapath. It sits directly in front of the 64-page × 25-bit state memory, acts as the memory's master, and applies the Keccak θ step in place. Each memory page z holds one slice of the 5×5 state: bit 5*y+x is A[x][y][z]. The pass takes two sweeps over the memory: a parity sweep, then a read-modify-write sweep. It then pulses `done` so the next round stage can take over the memory port.

---
 rtl/keccak_pkg.sv | 20 ++
 rtl/theta_column.sv | 18 +
 rtl/theta_stage.sv | 132 +++++++++++++
 tb/tb_theta_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared constants, state encoding and lane indexing for the Keccak round stages.
// A memory page holds one 5x5 slice; lane (x,y) of the slice sits at bit idx(x,y).
package keccak_pkg;

    localparam int PAGES  = 64;
    localparam int PAGE_W = 6;
    localparam int WORD_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PARITY = 2'd1,
        ST_APPLY  = 2'd2,
        ST_DONE   = 2'd3
    } theta_state_e;

    function automatic int unsigned idx(input int unsigned x, input int unsigned y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/theta_column.sv
// Column parity of one slice: col_parity[x] is the XOR of the five lanes in column x.
module theta_column
    import keccak_pkg::*;
(
    input  logic [24:0] word,
    output logic [4:0]  col_parity
);

    always_comb begin
        col_parity = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                col_parity[x] = col_parity[x] ^ word[idx(x, y)];
            end
        end
    end

endmodule

// File: rtl/theta_stage.sv
// In-place Keccak theta over the slice memory: a parity sweep fills a column-parity
// buffer, then a read-modify-write sweep XORs each slice with its D vector.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   IDLE   | memory port parked at page 0, waiting for start
//   PARITY | read page counter, store its column parity in the buffer
//   APPLY  | read page counter, write back rdata ^ D
//   DONE   | one-cycle done pulse, then back to IDLE
module theta_stage
    import keccak_pkg::*;
#(
    parameter int PAGES  = keccak_pkg::PAGES,
    parameter int PAGE_W = keccak_pkg::PAGE_W,
    parameter int WORD_W = keccak_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [PAGE_W-1:0] page,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_write
);

    theta_state_e      state_q, state_d;
    logic [PAGE_W-1:0] counter_q, counter_d;
    logic              last_page;

    logic [4:0]        col_parity;
    logic              buf_we;
    logic [4:0]        parity_buf_q [PAGES];
    logic [4:0]        c_cur, c_prev;
    logic [4:0]        d_vec;

    assign last_page = (counter_q == PAGE_W'(PAGES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (start) state_d = ST_PARITY;
            end
            ST_PARITY: begin
                // counter wraps to 0 on the last page, ready for the APPLY sweep
                counter_d = counter_q + PAGE_W'(1);
                if (last_page) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                counter_d = counter_q + PAGE_W'(1);
                if (last_page) state_d = ST_DONE;
            end
            ST_DONE: begin
                counter_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                counter_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_write = 1'b0;
        buf_we    = 1'b0;
        page      = '0;
        case (state_q)
            ST_PARITY: begin
                busy   = 1'b1;
                buf_we = 1'b1;
                page   = counter_q;
            end
            ST_APPLY: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                page      = counter_q;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    theta_column u_theta_column (
        .word       (mem_rdata),
        .col_parity (col_parity)
    );

    // Every entry is written in PARITY before APPLY reads it, so no reset is needed.
    always_ff @(posedge clk) begin
        if (buf_we) parity_buf_q[counter_q] <= col_parity;
    end

    // Page 0 picks up the previous slice from entry PAGES-1 via the natural wrap.
    assign c_cur  = parity_buf_q[counter_q];
    assign c_prev = parity_buf_q[counter_q - PAGE_W'(1)];

    always_comb begin
        d_vec = '0;
        for (int x = 0; x < 5; x++) begin
            d_vec[x] = c_cur[(x + 4) % 5] ^ c_prev[(x + 1) % 5];
        end
    end

    always_comb begin
        mem_wdata = '0;
        if (state_q == ST_APPLY) begin
            for (int x = 0; x < 5; x++) begin
                for (int y = 0; y < 5; y++) begin
                    mem_wdata[idx(x, y)] = mem_rdata[idx(x, y)] ^ d_vec[x];
                end
            end
        end
    end

endmodule

// File: tb/tb_theta_stage.sv
// Directed bench for theta_stage with a behavioural 64x25 slice memory.
module tb_theta_stage;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  page;
    logic [24:0] mem_rdata;
    logic [24:0] mem_wdata;
    logic        mem_write;

    logic [24:0] mem      [64];
    logic [24:0] init_mem [64];
    logic [24:0] orig_mem [64];
    logic [24:0] exp_mem  [64];
    logic        load;
    int          wr_cnt;
    int          n_cmp;
    int          n_fail;

    theta_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .page      (page),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[page];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (mem_write === 1'b1) begin
            mem[page] <= mem_wdata;
            wr_cnt    <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_mem();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
        for (int i = 0; i < 64; i++) orig_mem[i] = init_mem[i];
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < 64; i++) chk($sformatf("%s[%0d]", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    // Straight from the theta definition over (x,y,z), used for randomised contents.
    task automatic ref_theta();
        logic [4:0] c [64];
        for (int z = 0; z < 64; z++) begin
            c[z] = '0;
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) c[z][x] = c[z][x] ^ orig_mem[z][5*y+x];
        end
        for (int z = 0; z < 64; z++)
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    exp_mem[z][5*y+x] = orig_mem[z][5*y+x] ^ c[z][(x+4)%5] ^ c[(z+63)%64][(x+1)%5];
    endtask

    task automatic do_pass(input bit poke, input int abort_pg);
        int  done_cyc, busy_cnt, done_cnt, wr0;
        bit  aborted;
        done_cyc = -1; busy_cnt = 0; done_cnt = 0; aborted = 1'b0;
        wr0 = wr_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= 140 && !aborted; cyc++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 1) begin
                chk("parity_first_page", 32'(page), 32'd0);
                chk("parity_no_write", 32'(mem_write), 32'd0);
            end
            if (cyc == 64) chk("parity_last_page", 32'(page), 32'd63);
            if (cyc == 65) begin
                chk("apply_first_page", 32'(page), 32'd0);
                chk("apply_write", 32'(mem_write), 32'd1);
            end
            if (cyc == 128) chk("apply_last_page", 32'(page), 32'd63);
            if (cyc == 129) chk("done_no_write", 32'(mem_write), 32'd0);
            if (abort_pg >= 0 && cyc == 65 + abort_pg) begin
                chk("abort_page", 32'(page), 32'(abort_pg));
                rst_n = 1'b0;
                #1;
                chk("abort_write_drop", 32'(mem_write), 32'd0);
                chk("abort_busy_drop", 32'(busy), 32'd0);
                chk("abort_page_zero", 32'(page), 32'd0);
                chk("abort_wdata_zero", 32'(mem_wdata), 32'd0);
                @(negedge clk); rst_n = 1'b1;
                aborted = 1'b1;
            end else begin
                start = poke && (cyc == 10 || cyc == 90);
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (aborted) begin
            chk("abort_writes", 32'(wr_cnt - wr0), 32'(abort_pg));
            chk("abort_no_done", 32'(done_cnt), 32'd0);
        end else begin
            chk("done_cycle", 32'(done_cyc), 32'd129);
            chk("busy_cycles", 32'(busy_cnt), 32'd128);
            chk("done_count", 32'(done_cnt), 32'd1);
            chk("write_count", 32'(wr_cnt - wr0), 32'd64);
            chk("idle_after", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; wr_cnt = 0;
        rst_n = 1'b0; start = 1'b0; load = 1'b0;
        for (int i = 0; i < 64; i++) begin
            init_mem[i] = '0;
            mem[i]      = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_write", 32'(mem_write), 32'd0);
        chk("rst_page", 32'(page), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;

        // All-zero memory stays zero.
        load_mem();
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        do_pass(1'b0, -1);
        chk_mem("zero");

        // All-ones pages: every column parity is 1, so D is 0.
        for (int i = 0; i < 64; i++) init_mem[i] = 25'h1FFFFFF;
        load_mem();
        for (int i = 0; i < 64; i++) exp_mem[i] = 25'h1FFFFFF;
        do_pass(1'b0, -1);
        chk_mem("ones");

        // Single bit in page 0.
        for (int i = 0; i < 64; i++) init_mem[i] = '0;
        init_mem[0] = 25'h0000001;
        load_mem();
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        exp_mem[0] = 25'h0210843;
        exp_mem[1] = 25'h1084210;
        do_pass(1'b0, -1);
        chk_mem("bit_p0");

        // Same vector with start re-asserted during PARITY and APPLY.
        load_mem();
        do_pass(1'b1, -1);
        chk_mem("bit_p0_restart");

        // Single bit in page 63: D wraps into page 0.
        for (int i = 0; i < 64; i++) init_mem[i] = '0;
        init_mem[63] = 25'h0000001;
        load_mem();
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        exp_mem[63] = 25'h0210843;
        exp_mem[0]  = 25'h1084210;
        do_pass(1'b0, -1);
        chk_mem("bit_p63");

        // Reset while page 15 is being written, then a full fresh pass.
        for (int i = 0; i < 64; i++) init_mem[i] = 25'($urandom);
        load_mem();
        ref_theta();
        for (int i = 15; i < 64; i++) exp_mem[i] = orig_mem[i];
        do_pass(1'b0, 15);
        chk_mem("abort");
        for (int i = 0; i < 64; i++) orig_mem[i] = mem[i];
        ref_theta();
        do_pass(1'b0, -1);
        chk_mem("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
